// File: rtl/crc8_pkg.sv
// crc8_pkg: shared constants and state type for the CRC-8 serial framing path.
// Build option: define CRC8_TX_INIT_ONES_EN to start every frame's CRC at 8'hFF
// instead of 8'h00.
package crc8_pkg;

    // G(x) = x^8 + x^2 + x + 1, non-reflected
    localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef CRC8_TX_INIT_ONES_EN
    localparam logic [7:0] CRC8_INIT = 8'hFF;
`else
    localparam logic [7:0] CRC8_INIT = 8'h00;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_CRC,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/crc8_bit_step.sv
// crc8_bit_step: one bit of the MSB-first CRC-8 recurrence. Purely combinational
// so the transmitter and any downstream checker compute identical remainders.
module crc8_bit_step
    import crc8_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic       i_bit,
    output logic [7:0] o_crc_next
);

    logic w_fb;

    assign w_fb       = i_crc[7] ^ i_bit;
    assign o_crc_next = {i_crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);

endmodule

// File: rtl/crc8_frame_tx.sv
// crc8_frame_tx: accepts payload bytes over valid/ready, shifts them out MSB-first
// with per-bit backpressure, and appends the 8-bit CRC after the byte marked last.
// Build option: CRC8_TX_INIT_ONES_EN selects an all-ones CRC seed (see crc8_pkg).
module crc8_frame_tx
    import crc8_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       ser_bit,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_crc,
    output logic       ser_last,
    output logic [7:0] crc_out,
    output logic       crc_done
);

    // Terminal value of the gap counter; unused when IDLE_GAP is zero.
    localparam logic [7:0] GAP_LAST = (IDLE_GAP == 0) ? 8'd0 : 8'(IDLE_GAP - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [7:0] r_shreg;
    logic [2:0] r_cnt;
    logic       r_last;
    logic [7:0] r_crc;
    logic [7:0] r_crc_out;
    logic [7:0] r_gap_cnt;

    logic       w_in_ready;
    logic       w_ser_valid;
    logic       w_ser_crc;
    logic       w_ser_last;
    logic       w_crc_done;
    logic       w_cnt_wrap;
    logic       w_accept;
    logic       w_xfer;
    logic [7:0] w_crc_next;

    assign w_cnt_wrap = (r_cnt == 3'd7);
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = w_ser_valid && ser_ready;

    // CRC advances on the bit currently presented, i.e. the one being transferred.
    crc8_bit_step u_step (
        .i_crc      (r_crc),
        .i_bit      (r_shreg[7]),
        .o_crc_next (w_crc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers sample
        // the same pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; ser_valid is a pure function of state so it
    // never waits on ser_ready, while in_ready may follow ser_ready in the same cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_ser_valid  = 1'b0;
        w_ser_crc    = 1'b0;
        w_ser_last   = 1'b0;
        w_crc_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_ser_valid = 1'b1;
                w_in_ready  = w_cnt_wrap && ser_ready && !r_last;
                if (ser_ready && w_cnt_wrap) begin
                    if (r_last)        w_state_next = ST_CRC;
                    else if (in_valid) w_state_next = ST_DATA;
                    else               w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_next = ST_DATA;
            end
            ST_CRC: begin
                w_ser_valid = 1'b1;
                w_ser_crc   = 1'b1;
                w_ser_last  = w_cnt_wrap;
                if (ser_ready && w_cnt_wrap) begin
                    w_crc_done   = 1'b1;
                    w_state_next = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Hold the interface quiet while reset is asserted, whatever the state.
        if (rst) begin
            w_in_ready  = 1'b0;
            w_ser_valid = 1'b0;
            w_ser_crc   = 1'b0;
            w_ser_last  = 1'b0;
            w_crc_done  = 1'b0;
        end
    end

    // Datapath: shift register, bit counter, running CRC, result and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= 8'h00;
            r_cnt     <= 3'd0;
            r_last    <= 1'b0;
            r_crc     <= CRC8_INIT;
            r_crc_out <= 8'h00;
            r_gap_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (w_accept) begin
                        r_shreg <= in_data;
                        r_cnt   <= 3'd0;
                        r_last  <= in_last;
                        // A frame starts only from IDLE; WAIT resumes one in progress.
                        if (r_state == ST_IDLE) r_crc <= CRC8_INIT;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_crc   <= w_crc_next;
                        r_cnt   <= r_cnt + 3'd1;
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        if (w_cnt_wrap) begin
                            if (r_last) begin
                                // Final remainder becomes the trailer.
                                r_shreg <= w_crc_next;
                            end else if (w_accept) begin
                                r_shreg <= in_data;
                                r_last  <= in_last;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (w_xfer) begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        if (w_cnt_wrap) begin
                            r_crc_out <= r_crc;
                            r_crc     <= CRC8_INIT;
                            r_gap_cnt <= 8'd0;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign ser_valid = w_ser_valid;
    assign ser_bit   = w_ser_valid ? r_shreg[7] : 1'b0;
    assign ser_crc   = w_ser_crc;
    assign ser_last  = w_ser_last;
    assign crc_done  = w_crc_done;
    assign crc_out   = r_crc_out;

endmodule

// File: tb/tb_crc8_frame_tx.sv
// tb_crc8_frame_tx: directed bench for crc8_frame_tx. Instance u_dut uses
// IDLE_GAP=0, instance u_gap uses IDLE_GAP=3 for the inter-frame gap checks.
// Honours CRC8_TX_INIT_ONES_EN for the expected CRC values.
module tb_crc8_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_crc;
    logic       ser_last;
    logic [7:0] crc_out;
    logic       crc_done;

    logic       g_rst;
    logic [7:0] g_in_data;
    logic       g_in_valid;
    logic       g_in_last;
    logic       g_in_ready;
    logic       g_ser_bit;
    logic       g_ser_valid;
    logic       g_ser_ready;
    logic       g_ser_crc;
    logic       g_ser_last;
    logic [7:0] g_crc_out;
    logic       g_crc_done;

    int         tests;
    int         fails;

    logic [7:0] fb [16];
    int         fn;

    logic [7:0] str_crc;
    logic [7:0] one_byte;
    logic [7:0] one_crc;

    crc8_frame_tx #(.IDLE_GAP(0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_crc   (ser_crc),
        .ser_last  (ser_last),
        .crc_out   (crc_out),
        .crc_done  (crc_done)
    );

    crc8_frame_tx #(.IDLE_GAP(3)) u_gap (
        .clk       (clk),
        .rst       (g_rst),
        .in_data   (g_in_data),
        .in_valid  (g_in_valid),
        .in_last   (g_in_last),
        .in_ready  (g_in_ready),
        .ser_bit   (g_ser_bit),
        .ser_valid (g_ser_valid),
        .ser_ready (g_ser_ready),
        .ser_crc   (g_ser_crc),
        .ser_last  (g_ser_last),
        .crc_out   (g_crc_out),
        .crc_done  (g_crc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

`ifdef CRC8_TX_INIT_ONES_EN
    // Bitwise reference over fb[0..fn-1], seeded with all ones.
    function automatic logic [7:0] crc_model();
        logic [7:0] c;
        logic       f;
        c = 8'hFF;
        for (int i = 0; i < fn; i++) begin
            for (int b = 7; b >= 0; b--) begin
                f = c[7] ^ fb[i][b];
                c = {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction
`endif

    task automatic load_str();
        fn = 9;
        for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    endtask

    // Streams fb[0..fn-1] through u_dut and checks the serial output.
    // mode 0: ser_ready held high; 1: random ser_ready; 2: 5-cycle underrun after byte 0.
    // abort_at > 0 returns (mid-cycle, after the sample) once that many bits transferred.
    task automatic run_frame(input int mode, input int abort_at, input logic [7:0] exp_crc,
                             input string tag);
        int   idx = 0, nbits = 0, cyc = 0, acc0 = -1, first_v = -1, last_x = -1;
        int   nvalid = 0, ndone = 0, bit_err = 0, stall_err = 0, wait_err = 0, wc = 0;
        int   total;
        bit   done = 0, aborted = 0, prev_stall = 0;
        logic pb, pc, pl, exp_b;
        total = 8 * fn + 8;
        while (!done && cyc < 3000) begin
            in_valid = (idx < fn);
            if (mode == 2 && idx == 1 && (nbits < 8 || wc < 5)) in_valid = 1'b0;
            in_data   = (idx < fn) ? fb[idx] : 8'h00;
            in_last   = (idx == fn - 1);
            ser_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && !(ser_valid === 1'b1 && ser_bit === pb && ser_crc === pc &&
                                ser_last === pl)) stall_err++;
            prev_stall = ser_valid && !ser_ready;
            pb = ser_bit;
            pc = ser_crc;
            pl = ser_last;
            if (ser_valid) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
            end
            if (crc_done) ndone++;
            if (mode == 2 && idx == 1 && nbits >= 8) begin
                if (ser_valid !== 1'b0 || in_ready !== 1'b1) wait_err++;
                wc++;
            end
            if (ser_valid && ser_ready) begin
                if (nbits < 8 * fn) exp_b = fb[nbits / 8][7 - (nbits % 8)];
                else                exp_b = exp_crc[7 - (nbits - 8 * fn)];
                if (ser_bit !== exp_b || ser_crc !== (nbits >= 8 * fn) ||
                    ser_last !== (nbits == total - 1)) bit_err++;
                nbits++;
                last_x = cyc;
                if (ser_last) done = 1;
            end
            if (in_valid && in_ready) begin
                if (idx == 0) acc0 = cyc;
                idx++;
            end
            if (abort_at > 0 && nbits == abort_at) begin
                aborted = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        if (abort_at > 0) begin
            check({tag, " abort point"}, 32'(aborted), 32'd1);
            return;
        end
        check({tag, " finished"}, 32'(done), 32'd1);
        check({tag, " bit errors"}, 32'(bit_err), 32'd0);
        check({tag, " bit count"}, 32'(nbits), 32'(total));
        check({tag, " first bit latency"}, 32'(first_v), 32'(acc0 + 1));
        check({tag, " crc_done pulses"}, 32'(ndone), 32'd1);
        check({tag, " crc_out"}, 32'(crc_out), 32'(exp_crc));
        if (mode == 0) begin
            check({tag, " contiguous span"}, 32'(last_x - first_v + 1), 32'(total));
            check({tag, " valid cycles"}, 32'(nvalid), 32'(total));
        end
        if (mode == 1) check({tag, " stall stability"}, 32'(stall_err), 32'd0);
        if (mode == 2) begin
            check({tag, " wait state"}, 32'(wait_err), 32'd0);
            check({tag, " wait cycles"}, 32'(wc), 32'd6);
        end
    endtask

    initial begin
        int found;
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        ser_ready   = 1'b1;
        g_rst       = 1'b1;
        g_in_data   = 8'h00;
        g_in_valid  = 1'b0;
        g_in_last   = 1'b0;
        g_ser_ready = 1'b1;
        load_str();
`ifdef CRC8_TX_INIT_ONES_EN
        str_crc  = crc_model();
        one_byte = 8'h00;
        one_crc  = 8'hF3;
`else
        str_crc  = 8'hF4;
        one_byte = 8'h01;
        one_crc  = 8'h07;
`endif

        // Reset behaviour.
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst ser_valid", 32'(ser_valid), 32'd0);
        check("rst crc_out", 32'(crc_out), 32'h00);
        check("rst ser_bit", 32'(ser_bit), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst ser_valid", 32'(ser_valid), 32'd0);
        check("post-rst ser_crc/last/done", 32'({ser_crc, ser_last, crc_done}), 32'd0);
        @(posedge clk);
        #1;

        // Check string, full-rate.
        run_frame(0, 0, str_crc, "str");
        // Single byte frame.
        fn    = 1;
        fb[0] = one_byte;
        run_frame(0, 0, one_crc, "single");
        // Check string under random backpressure.
        load_str();
        run_frame(1, 0, str_crc, "stall");
        // Check string with an underrun after the first byte.
        run_frame(2, 0, str_crc, "underrun");

        // Reset in the middle of a frame.
        run_frame(0, 20, str_crc, "midrst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst ser_valid", 32'(ser_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst crc_out cleared", 32'(crc_out), 32'h00);
        check("midrst ser_bit/crc/last/done", 32'({ser_bit, ser_crc, ser_last, crc_done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst idle in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        fn    = 1;
        fb[0] = one_byte;
        run_frame(0, 0, one_crc, "after midrst");

        // Inter-frame gap on the IDLE_GAP=3 instance.
        g_rst = 1'b0;
        @(negedge clk);
        check("gap idle in_ready", 32'(g_in_ready), 32'd1);
        @(posedge clk);
        #1;
        g_in_data  = one_byte;
        g_in_valid = 1'b1;
        g_in_last  = 1'b1;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (g_ser_valid && g_ser_last) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
            // Second frame's byte queued as soon as the first one is in flight.
            if (g_ser_valid) g_in_data = 8'h80;
        end
        check("gap first frame end", 32'(found), 32'd1);
        check("gap crc_done", 32'(g_crc_done), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("gap cycle %0d ser_valid", k), 32'(g_ser_valid), 32'd0);
            check($sformatf("gap cycle %0d in_ready", k), 32'(g_in_ready), 32'd0);
        end
        check("gap crc_out", 32'(g_crc_out), 32'(one_crc));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("gap back to idle in_ready", 32'(g_in_ready), 32'd1);
        @(posedge clk);
        #1;
        g_in_valid = 1'b0;
        @(negedge clk);
        check("gap next frame ser_valid", 32'(g_ser_valid), 32'd1);
        check("gap next frame msb", 32'(g_ser_bit), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc8_frame_tx.md
# crc8_frame_tx

Byte-to-serial framing stage feeding the team's bit-serial CRC-8 datapath (G(x) = x^8+x^2+x+1). Accepts bytes over a valid/ready interface, serializes them MSB-first onto a 1-bit stream, computes CRC-8 on the fly, and appends the 8 CRC bits after the byte flagged last. Downstream consumers apply backpressure per bit.

## Interface
- IDLE_GAP, default 0: number of idle bit-cycles forced between frames, 0..255.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  byte is final payload byte of frame.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- ser_bit  out  1  serial bit, MSB-first.
- ser_valid  out  1  ser_bit valid.
- ser_ready  in  1  downstream takes bit when ser_valid && ser_ready.
- ser_crc  out  1  current bit belongs to CRC trailer.
- ser_last  out  1  current bit is final CRC bit.
- crc_out  out  8  CRC of last completed frame.
- crc_done  out  1  one-cycle pulse when final CRC bit transfers.

## Operation
- CRC step per payload bit b: fb = crc[7]^b; crc_next = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00). No reflection, no final XOR.
- CRC register set to init value at frame start (first byte accepted in IDLE) and after trailer completes; held across underruns.
- States: IDLE, DATA, WAIT, CRC, GAP. Reset -> IDLE.
- IDLE: in_ready=1, ser_valid=0. Accept -> load shreg, cnt=0, latch last_q, init CRC -> DATA.
- DATA: ser_valid=1, ser_bit=shreg[7]. On transfer: CRC step, shift, cnt++. On transfer with cnt==7:
  - last_q=1 -> load shreg with crc_next (final CRC), cnt=0 -> CRC.
  - else in_valid=1 -> load next byte (in_ready asserted combinationally this cycle) -> DATA, no bubble.
  - else -> WAIT.
- WAIT: in_ready=1, ser_valid=0, CRC held; accept -> DATA.
- CRC: ser_valid=1, ser_crc=1, ser_bit=shreg[7]; on transfer shift, cnt++. cnt==7 transfer: ser_last=1, crc_out<=final CRC, crc_done=1, CRC reg <= init -> GAP if IDLE_GAP>0 else IDLE.
- GAP: ser_valid=0, in_ready=0, count IDLE_GAP cycles -> IDLE.
- in_ready = IDLE || WAIT || (DATA && cnt==7 && ser_ready && !last_q). Combinational path ser_ready->in_ready permitted; in_ready never depends on in_valid.
- ser_valid never depends on ser_ready; ser_bit/ser_crc/ser_last stable while ser_valid && !ser_ready.
- in_last on a byte accepted in WAIT or streaming applies identically.

## Timing
- While rst high and first cycle after: state IDLE; in_ready=0 during rst, 1 afterwards; ser_valid, ser_crc, ser_last, crc_done=0; crc_out=8'h00; ser_bit=0.
- rst mid-frame: frame abandoned, no trailer, crc_out unchanged? No: crc_out cleared to 00.
- Latency: byte accepted cycle N -> its MSB on ser_bit at N+1.
- With ser_ready=1 and in_valid continuous: frame of K bytes occupies 8K+8 contiguous ser_valid cycles; next frame's first bit IDLE_GAP+2 cycles after ser_last.
- crc_done coincident with ser_last transfer cycle; crc_out updated the cycle after.

## Configuration
- CRC8_TX_INIT_ONES_EN defined: CRC init value 8'hFF.
- Undefined: CRC init value 8'h00.
- No other behavioural difference; crc_out reset value 8'h00 either way.

## Structure
- Package crc8_pkg: CRC8_POLY = 8'h07, CRC8_INIT (macro-selected), state enum typedef.
- Sub-module crc8_bit_step: combinational (crc, bit) -> crc_next, also reused by checker stage.
- Top: FSM, bit counter, shift register, gap counter.

## Test plan
- Frame "123456789" (0x31..0x39, last on 0x39), ser_ready=1, init 00 -> 80 contiguous bits, trailer bits 1,1,1,1,0,1,0,0, crc_out=0xF4, one crc_done pulse.
- Single byte 0x01 last -> bits 00000001 then 00000111; crc_out=0x07; with CRC8_TX_INIT_ONES_EN, byte 0x00 -> crc_out=0xF3.
- Random ser_ready deassertion (~50%) on "123456789" -> identical bit sequence, ser_bit stable when stalled, crc_out=0xF4.
- Underrun: 0x31 sent, in_valid low 5 cycles (WAIT, ser_valid=0), remaining bytes -> crc_out=0xF4.
- IDLE_GAP=3, two back-to-back frames -> exactly 3 cycles of ser_valid=0 and in_ready=0 after ser_last, then IDLE.
- rst asserted at bit 20 of a frame -> next cycle all outputs at reset values; new frame 0x01 -> crc_out=0x07 (no carried CRC state).
